countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Programmable down-counter: loads a value from switches, decrements it once per prescaled tick, and signals expiry when it reaches zero.
- It is the decrementing counterpart of the 1 Hz LED up-counter and drives the same 4-bit LEDR bank.
- Start and pause come from pre-synchronised push-button levels; the block detects their rising edges internally.
- `o_expire` is intended to drive downstream alarm or sequencing logic.

Parameters:
- WIDTH, 4: width of the count, load value and LEDR.
- TICK_DIV, 25000000: clock cycles per decrement tick. Must be ≥ 2. Use 4 in simulation.
- PRESC_W, 32: prescaler register width. Must satisfy 2^PRESC_W > TICK_DIV.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_start  input  1  start/restart button level; rising edge acts
- i_pause  input  1  pause/resume button level; rising edge acts
- i_load_val  input  WIDTH  value loaded on start
- LEDR  output  WIDTH  current count (registered)
- o_busy  output  1  high in RUN or PAUSE
- o_done  output  1  high while in DONE
- o_expire  output  1  one-cycle pulse on entry to DONE
- o_tick  output  1  one-cycle pulse on each prescaler tick while in RUN

Behaviour:
- **Reset** (i_rst=1 at a clock edge, overrides everything):
  - state=IDLE; LEDR=0; prescaler=0.
  - o_busy, o_done, o_expire and o_tick all 0.
  - start_prev=1 and pause_prev=1. A button already held at reset release does not trigger; it must go low, then high.
- **Edge detect:**
  - start_edge = i_start & ~start_prev; pause_edge = i_pause & ~pause_prev.
  - The prev registers update every non-reset cycle.
- **Prescaler:**
  - Counts only in RUN.
  - tick = (state==RUN) & (prescaler==TICK_DIV-1); on tick, prescaler returns to 0, otherwise it increments.
  - It holds its value in PAUSE and is cleared on every load.
- **States:** IDLE, RUN, PAUSE, DONE.
- **Load action:**
  - Fires on a start_edge in any state: LEDR←i_load_val, prescaler←0.
  - If i_load_val==0, go to DONE and pulse o_expire; otherwise go to RUN.
  - start_edge has priority over pause_edge and over tick in the same cycle.
- **IDLE:** holds LEDR. pause_edge is ignored.
- **RUN:**
  - On tick: LEDR←LEDR-1 and o_tick=1 for that cycle.
  - If the tick occurs with LEDR==1: LEDR becomes 0, next state DONE, o_expire=1 on that same edge.
  - On pause_edge without tick: go to PAUSE.
  - tick and pause_edge in the same cycle: apply the decrement (and expiry if reached), then go to PAUSE, unless expiry occurred, in which case go to DONE.
- **PAUSE:** LEDR and prescaler frozen. pause_edge returns to RUN and counting resumes from the held prescaler value.
- **DONE:** LEDR=0 and o_done=1. Only start_edge leaves this state. pause_edge is ignored.
- **Latency:**
  - A start_edge sampled at edge k makes LEDR=i_load_val visible after edge k.
  - The first decrement is at edge k+TICK_DIV; later decrements follow every TICK_DIV RUN cycles.
- **Wrap and width rules:**
  - LEDR never wraps below 0; the count stops at 0 in DONE.
  - i_load_val is used at full WIDTH, so the maximum count is 2^WIDTH-1.
- **Output timing:** o_busy and o_done are derived from registered state (no combinational path from inputs). o_expire and o_tick are registered pulses.

Optional Feature:
- **COUNTDOWN_AUTO_RELOAD_EN defined:**
  - When RUN expires (LEDR 1→0 on a tick), the block reloads LEDR←i_load_val on that same edge and stays in RUN. o_expire still pulses, but DONE is not entered.
  - If i_load_val==0 at that moment, the block enters DONE as normal.
  - A zero-load start still goes directly to DONE.
- **Undefined:** behaviour as specified above, with expiry always entering DONE.

Test Plan:
- Reset release with i_start held high, then held further (TICK_DIV=4) -> no load; LEDR=0, state IDLE until i_start goes low and high again.
- i_load_val=3, start pulse at edge k -> LEDR=3 after k, then 2 at k+4, 1 at k+8, 0 at k+12; o_expire high for exactly the cycle after k+12; o_done stays 1; o_busy 1 from k to k+12.
- Load 5, pause at prescaler=2, hold 10 cycles, resume -> LEDR stays 5 during pause; the decrement to 4 lands 2 RUN cycles after resume.
- Start and pause edges in the same cycle while in RUN with LEDR=2 -> reload to i_load_val, state RUN, prescaler=0, pause ignored.
- i_load_val=0 start -> DONE on the next edge, o_expire pulse, o_busy never high. With COUNTDOWN_AUTO_RELOAD_EN and load 2 -> sequence 2,1,2,1… with o_expire pulsing every 8 cycles.
- i_rst asserted mid-RUN (LEDR=4, prescaler=3) -> after that edge LEDR=0, IDLE, all outputs 0, and no tick is emitted on the reset cycle.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Programmable down-counter. A rising edge on the start button loads the
// switch value into the count. While running, the count decrements once every
// TICK_DIV clock cycles. When the count reaches zero the block raises o_expire
// for one cycle and parks in DONE. The pause button freezes and resumes the
// count. LEDR shows the current count.
//
// Optional feature (compile-time macro COUNTDOWN_AUTO_RELOAD_EN):
//   When this macro is defined and a running count expires, the count reloads
//   from i_load_val on the same edge and the block stays in RUN. o_expire still
//   pulses. If i_load_val is zero at that moment, the block enters DONE as usual.
//
// Parameters:
//   WIDTH    - width of the count, the load value and LEDR
//   TICK_DIV - clock cycles per decrement tick (must be >= 2)
//   PRESC_W  - prescaler width (2**PRESC_W must exceed TICK_DIV)
//
// Ports:
//   i_clk      - system clock; all logic uses its rising edge
//   i_rst      - synchronous, active-high reset
//   i_start    - start/restart button level (pre-synchronised); rising edge acts
//   i_pause    - pause/resume button level (pre-synchronised); rising edge acts
//   i_load_val - value loaded on start
//   LEDR       - current count (registered)
//   o_busy     - high in RUN or PAUSE
//   o_done     - high while in DONE
//   o_expire   - one-cycle pulse on each expiry
//   o_tick     - one-cycle pulse after each decrement tick in RUN
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 25000000,
  parameter int PRESC_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] LEDR,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_expire,
  output logic             o_tick
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0]   COUNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   count;
  logic [PRESC_W-1:0] presc;
  logic               start_prev;
  logic               pause_prev;
  logic               expire_r;
  logic               tick_r;

  logic start_edge;
  logic pause_edge;
  logic tick;
  logic load_zero;

  // The prev registers reset high, so a button that is already held when
  // reset releases must be released and pressed again before it acts.
  assign start_edge = i_start & ~start_prev;
  assign pause_edge = i_pause & ~pause_prev;
  assign tick       = (state == S_RUN) && (presc == PRESC_LAST);
  assign load_zero  = (i_load_val == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      count      <= '0;
      presc      <= '0;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      expire_r   <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      start_prev <= i_start;
      pause_prev <= i_pause;
      expire_r   <= 1'b0;
      tick_r     <= 1'b0;

      if (start_edge) begin
        // A restart overrides a pending pause or tick in the same cycle.
        count <= i_load_val;
        presc <= '0;
        if (load_zero) begin
          state    <= S_DONE;
          expire_r <= 1'b1;
        end else begin
          state    <= S_RUN;
        end
      end else begin
        case (state)
          S_RUN: begin
            if (tick) begin
              presc  <= '0;
              tick_r <= 1'b1;
              if (count == COUNT_ONE) begin
                expire_r <= 1'b1;
                if (AUTO_RELOAD && !load_zero) begin
                  count <= i_load_val;
                  if (pause_edge) begin
                    state <= S_PAUSE;
                  end
                end else begin
                  // Expiry wins over a simultaneous pause.
                  count <= '0;
                  state <= S_DONE;
                end
              end else begin
                count <= count - COUNT_ONE;
                if (pause_edge) begin
                  state <= S_PAUSE;
                end
              end
            end else begin
              presc <= presc + PRESC_W'(1);
              if (pause_edge) begin
                state <= S_PAUSE;
              end
            end
          end
          S_PAUSE: begin
            // The count and the prescaler stay frozen, so counting resumes
            // mid-period rather than restarting the tick interval.
            if (pause_edge) begin
              state <= S_RUN;
            end
          end
          default: begin
            // IDLE and DONE only leave on a start edge, handled above.
          end
        endcase
      end
    end
  end

  assign LEDR     = count;
  assign o_busy   = (state == S_RUN) || (state == S_PAUSE);
  assign o_done   = (state == S_DONE);
  assign o_expire = expire_r;
  assign o_tick   = tick_r;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Scoreboard bench for countdown_timer. The stimulus process drives the inputs
// on the falling edge. It advances a behavioural model, built from run-cycle
// counts, to predict the outputs after the next rising edge, and queues that
// prediction. A separate monitor samples the outputs shortly after each rising
// edge and compares them with the oldest queued prediction.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int PRESC_W  = 8;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] ledr;
  logic             busy;
  logic             done;
  logic             expire;
  logic             tick;

  always #5 clk = ~clk;

  countdown_timer #(
    .WIDTH   (WIDTH),
    .TICK_DIV(TICK_DIV),
    .PRESC_W (PRESC_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_pause   (pause),
    .i_load_val(load_val),
    .LEDR      (ledr),
    .o_busy    (busy),
    .o_done    (done),
    .o_expire  (expire),
    .o_tick    (tick)
  );

  typedef struct packed {
    logic [WIDTH-1:0] ledr;
    logic             busy;
    logic             done;
    logic             expire;
    logic             tick;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: the mode, the displayed count, and how many RUN cycles have
  // elapsed since the last load. A tick falls on every TICK_DIV-th RUN cycle.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
  int m_mode  = M_IDLE;
  int m_count = 0;
  int m_runs  = 0;
  bit m_sp    = 1'b1;
  bit m_pp    = 1'b1;

  task automatic step(input bit r, input bit s, input bit p, input logic [WIDTH-1:0] v);
    obs_t e;
    bit   se, pe, mt, mx;
    @(negedge clk);
    rst      = r;
    start    = s;
    pause    = p;
    load_val = v;
    mt = 1'b0;
    mx = 1'b0;
    if (r) begin
      m_mode  = M_IDLE;
      m_count = 0;
      m_runs  = 0;
      m_sp    = 1'b1;
      m_pp    = 1'b1;
    end else begin
      se   = s && !m_sp;
      pe   = p && !m_pp;
      m_sp = s;
      m_pp = p;
      if (se) begin
        m_runs  = 0;
        m_count = int'(v);
        if (v == 0) begin
          m_mode = M_DONE;
          mx     = 1'b1;
        end else begin
          m_mode = M_RUN;
        end
      end else if (m_mode == M_RUN) begin
        m_runs++;
        if (m_runs % TICK_DIV == 0) begin
          mt = 1'b1;
          m_count--;
          if (m_count == 0) begin
            mx = 1'b1;
            if (AUTO && v != 0) begin
              m_count = int'(v);
              if (pe) m_mode = M_PAUSE;
            end else begin
              m_mode = M_DONE;
            end
          end else if (pe) begin
            m_mode = M_PAUSE;
          end
        end else if (pe) begin
          m_mode = M_PAUSE;
        end
      end else if (m_mode == M_PAUSE && pe) begin
        m_mode = M_RUN;
      end
    end
    e.ledr   = m_count[WIDTH-1:0];
    e.busy   = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.done   = (m_mode == M_DONE);
    e.expire = mx;
    e.tick   = mt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [WIDTH-1:0] v);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, v);
  endtask

  // Monitor: compares DUT outputs with the oldest prediction.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{ledr: ledr, busy: busy, done: done, expire: expire, tick: tick};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got ledr=%0d busy=%b done=%b expire=%b tick=%b, expected ledr=%0d busy=%b done=%b expire=%b tick=%b",
                   $time, got.ledr, got.busy, got.done, got.expire, got.tick,
                   e.ledr, e.busy, e.done, e.expire, e.tick);
        end
      end
    end
  end

  initial begin
    bit               r_lvl;
    bit               s_lvl;
    bit               p_lvl;
    logic [WIDTH-1:0] v;

    // Reset with both buttons held, then keep holding: nothing may load.
    step(1'b1, 1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b1, 1'b1, 4'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd3);

    // Load 3 and run through to expiry and beyond.
    step(1'b0, 1'b1, 1'b0, 4'd3);
    idle(16, 4'd3);

    // Load 5, pause mid-period, hold, then resume.
    step(1'b0, 1'b1, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b0, 4'd5);
    idle(8, 4'd5);

    // Load 4, run down to 2, then start and pause together.
    step(1'b0, 1'b1, 1'b0, 4'd4);
    idle(8, 4'd4);
    step(1'b0, 1'b1, 1'b1, 4'd7);
    step(1'b0, 1'b0, 1'b0, 4'd7);
    idle(6, 4'd7);

    // Zero load goes straight to DONE; a pause in DONE is ignored.
    step(1'b0, 1'b1, 1'b0, 4'd0);
    idle(3, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    idle(2, 4'd0);

    // Reset in the middle of a run.
    step(1'b0, 1'b1, 1'b0, 4'd5);
    idle(7, 4'd5);
    step(1'b1, 1'b0, 1'b0, 4'd5);
    idle(3, 4'd5);

    // Load 2 and watch two expiry periods (auto-reload cycles when enabled).
    step(1'b0, 1'b1, 1'b0, 4'd2);
    idle(20, 4'd2);

    // Maximum load value.
    step(1'b0, 1'b1, 1'b0, 4'd15);
    idle(64, 4'd15);

    // Random button activity.
    r_lvl = 1'b0;
    s_lvl = 1'b0;
    p_lvl = 1'b0;
    v     = 4'd3;
    for (int i = 0; i < 4000; i++) begin
      r_lvl = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 19) == 0) p_lvl = ~p_lvl;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) == 0) v = WIDTH'($urandom_range(0, 15));
        else                           v = WIDTH'($urandom_range(0, 4));
      end
      step(r_lvl, s_lvl, p_lvl, v);
    end

    // Drain: every prediction must have been consumed by the monitor.
    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked predictions, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
